// File: rtl/eq_pkg.sv
// Shared constants, enums and the coefficient profile table for the
// equalizer IIR sequencer.
package eq_pkg;

  localparam int NBANDS = 4;
  localparam int DATA_W = 24;
  localparam int COEF_W = 17;
  localparam int FRAC   = 15;
  localparam int PROD_W = COEF_W + DATA_W;  // 41-bit signed product
  localparam int ACC_W  = 44;               // product + 3 guard bits
  localparam int NTAPS  = 5;
  localparam int NPROF  = 16;
  localparam int PROF_W = 4;
  localparam int BAND_W = $clog2(NBANDS);

  // Tap order inside one band; na1/na2 hold -a1/-a2 so every term adds.
  typedef enum logic [2:0] {
    TAP_B0  = 3'd0,
    TAP_B1  = 3'd1,
    TAP_B2  = 3'd2,
    TAP_NA1 = 3'd3,
    TAP_NA2 = 3'd4
  } tap_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WB    = 2'd3
  } state_e;

  // EQ_COEF[profile][band][tap], Q1.15 signed.
  typedef logic [NPROF-1:0][NBANDS-1:0][NTAPS-1:0][COEF_W-1:0] coef_tab_t;

  localparam logic [COEF_W-1:0] UNITY = 17'd32768;
  localparam logic [NTAPS*COEF_W-1:0] BAND_UNITY =
    {{((NTAPS-1)*COEF_W){1'b0}}, UNITY};

  // Every profile defaults to a unity pass-through; a few profiles
  // override individual bands.
  function automatic coef_tab_t build_coef_table();
    coef_tab_t t;
    t = {(NPROF*NBANDS){BAND_UNITY}};
    // Profile 1: band 0 halves the signal.
    t[1][0][TAP_B0]  = 17'd16384;
    // Profile 2: band 0 gain of ~2, drives the output into saturation.
    t[2][0][TAP_B0]  = 17'd65535;
    // Profile 3: band 0 two-tap average, band 1 leaky integrator.
    t[3][0][TAP_B0]  = 17'd16384;
    t[3][0][TAP_B1]  = 17'd16384;
    t[3][1][TAP_B0]  = 17'd16384;
    t[3][1][TAP_NA1] = 17'd16384;
    return t;
  endfunction

  localparam coef_tab_t EQ_COEF = build_coef_table();

  localparam logic signed [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Round half up, drop the fraction, clamp to the sample range.
  function automatic logic signed [DATA_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = (acc + ROUND_HALF) >>> FRAC;
    if (shifted > SAT_MAX)      shifted = SAT_MAX;
    else if (shifted < SAT_MIN) shifted = SAT_MIN;
    return shifted[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/eq_mac.sv
// Shared multiply-accumulate: registered 17x24 signed product feeding an
// ACC_W accumulator that adds one cycle after each issue.
module eq_mac
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] data,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] prod;

  // Product pipeline register, loaded on every issued tap.
  // NOTE: clocked state uses <= so every flop samples pre-edge values;
  // a blocking = here would let prod and acc race within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       prod <= '0;
    else if (issue) prod <= PROD_W'(coef) * PROD_W'(data);
  end

  // Accumulator: cleared on a band's first tap, then adds the prior product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + ACC_W'(prod);
  end

endmodule

// File: rtl/eq_biquad_seq.sv
// Time-multiplexed cascade of NBANDS biquads sharing one eq_mac.
// Each band takes 5 MAC cycles, one drain cycle and one write-back cycle.
module eq_biquad_seq
  import eq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] Xin,
  input  logic        [PROF_W-1:0] coe_ctrl,
  output logic signed [DATA_W-1:0] Yout,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  state_e              state, state_next;
  tap_e                tap, tap_next;
  logic [BAND_W-1:0]   band, band_next;

  logic                accept, issue, mac_clr, mac_en, wb;
  logic                last_band;

  logic [PROF_W-1:0]        profile;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] x1 [NBANDS];
  logic signed [DATA_W-1:0] x2 [NBANDS];
  logic signed [DATA_W-1:0] y1 [NBANDS];
  logic signed [DATA_W-1:0] y2 [NBANDS];

  logic signed [COEF_W-1:0] coef_sel;
  logic signed [DATA_W-1:0] data_sel;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] y_wb;

  assign busy      = (state != ST_IDLE);
  assign last_band = (band == BAND_W'(NBANDS-1));
  assign y_wb      = round_sat(acc);

  // Sequencer state, tap and band counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      tap   <= TAP_B0;
      band  <= '0;
    end else begin
      state <= state_next;
      tap   <= tap_next;
      band  <= band_next;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    tap_next   = tap;
    band_next  = band;
    accept     = 1'b0;
    issue      = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    wb         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sample_valid) begin
          accept     = 1'b1;
          state_next = ST_MAC;
          tap_next   = TAP_B0;
          band_next  = '0;
        end
      end
      ST_MAC: begin
        issue   = 1'b1;
        mac_clr = (tap == TAP_B0);
        mac_en  = (tap != TAP_B0);
        if (tap == TAP_NA2) state_next = ST_DRAIN;
        else                tap_next   = tap_e'(tap + 3'd1);
      end
      ST_DRAIN: begin
        mac_en     = 1'b1;
        state_next = ST_WB;
      end
      ST_WB: begin
        wb       = 1'b1;
        tap_next = TAP_B0;
        if (last_band) begin
          state_next = ST_IDLE;
        end else begin
          band_next  = band + 1'b1;
          state_next = ST_MAC;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand select for the current tap of the current band.
  always_comb begin
    coef_sel = $signed(EQ_COEF[profile][band][tap]);
    data_sel = x_in;
    case (tap)
      TAP_B0:  data_sel = x_in;
      TAP_B1:  data_sel = x1[band];
      TAP_B2:  data_sel = x2[band];
      TAP_NA1: data_sel = y1[band];
      TAP_NA2: data_sel = y2[band];
      default: data_sel = x_in;
    endcase
  end

  eq_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .issue (issue),
    .clr   (mac_clr),
    .en    (mac_en),
    .coef  (coef_sel),
    .data  (data_sel),
    .acc   (acc)
  );

  // Input latch, delay lines, band hand-off and output register.
  // NOTE: the delay-line arrays are ordinary flops and are reset, since a
  // reset mid-sample must leave no filter history behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      profile <= '0;
      x_in    <= '0;
      x1      <= '{default: '0};
      x2      <= '{default: '0};
      y1      <= '{default: '0};
      y2      <= '{default: '0};
      Yout    <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      overrun <= sample_valid && (state != ST_IDLE);
      if (accept) begin
        x_in    <= Xin;
        profile <= coe_ctrl;
      end
      if (wb) begin
        x2[band] <= x1[band];
        x1[band] <= x_in;
        y2[band] <= y1[band];
        y1[band] <= y_wb;
        x_in     <= y_wb;
        if (last_band) begin
          Yout    <= y_wb;
          y_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eq_biquad_seq.sv
// Self-checking bench for eq_biquad_seq against a floating-free integer
// model of the biquad cascade.
module tb_eq_biquad_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] Xin = '0;
  logic [3:0]  coe_ctrl = '0;
  logic [23:0] Yout;
  logic        y_valid, busy, overrun;

  int vectors     = 0;
  int miscompares = 0;

  // Reference filter history, per band.
  longint m_x1 [4];
  longint m_x2 [4];
  longint m_y1 [4];
  longint m_y2 [4];

  always #5 clk = ~clk;

  eq_biquad_seq dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .Xin          (Xin),
    .coe_ctrl     (coe_ctrl),
    .Yout         (Yout),
    .y_valid      (y_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Coefficients the bench expects for each profile/band/tap
  // (k: 0=b0, 1=b1, 2=b2, 3=-a1, 4=-a2).
  function automatic longint ref_coef(input int p, input int b, input int k);
    if (p == 1 && b == 0) return (k == 0) ? 16384 : 0;
    if (p == 2 && b == 0) return (k == 0) ? 65535 : 0;
    if (p == 3 && b == 0) return (k <= 1) ? 16384 : 0;
    if (p == 3 && b == 1) return (k == 0 || k == 3) ? 16384 : 0;
    return (k == 0) ? 32768 : 0;
  endfunction

  // floor((s + 0.5*2^15) / 2^15), clamped to 24-bit signed.
  function automatic longint ref_round_sat(input longint s);
    longint t, q;
    t = s + 16384;
    q = t / 32768;
    if (t < 0 && (t % 32768) != 0) q = q - 1;
    if (q > 8388607)  q = 8388607;
    if (q < -8388608) q = -8388608;
    return q;
  endfunction

  task automatic ref_reset();
    for (int b = 0; b < 4; b++) begin
      m_x1[b] = 0; m_x2[b] = 0; m_y1[b] = 0; m_y2[b] = 0;
    end
  endtask

  task automatic ref_sample(input logic [23:0] xin, input int p,
                            output logic [23:0] y);
    longint x, s, yb;
    x = longint'($signed(xin));
    for (int b = 0; b < 4; b++) begin
      s = ref_coef(p, b, 0) * x       + ref_coef(p, b, 1) * m_x1[b] +
          ref_coef(p, b, 2) * m_x2[b] + ref_coef(p, b, 3) * m_y1[b] +
          ref_coef(p, b, 4) * m_y2[b];
      yb = ref_round_sat(s);
      m_x2[b] = m_x1[b]; m_x1[b] = x;
      m_y2[b] = m_y1[b]; m_y1[b] = yb;
      x = yb;
    end
    y = x[23:0];
  endtask

  // Present one sample; returns at the falling edge of cycle T+1.
  task automatic send(input logic [23:0] x, input int p);
    @(negedge clk);
    sample_valid = 1'b1;
    Xin          = x;
    coe_ctrl     = 4'(p);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Counts cycles from T+1 until y_valid; -1 if it never comes.
  task automatic wait_yv(output int lat);
    lat = 1;
    while (y_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (y_valid !== 1'b1) lat = -1;
  endtask

  task automatic run_one(input logic [23:0] x, input int p, input string tag);
    logic [23:0] exp;
    int lat;
    ref_sample(x, p, exp);
    send(x, p);
    wait_yv(lat);
    vectors++;
    if (lat != 29) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles, expected 29", tag, lat);
    end
    vectors++;
    if (Yout !== exp) begin
      miscompares++;
      $display("FAIL %s_yout: got %h, expected %h", tag, Yout, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({Yout, y_valid, busy, overrun} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got Yout=%h yv=%b busy=%b ovr=%b, expected all 0",
               Yout, y_valid, busy, overrun);
    end
    rst = 1'b1;
    ref_reset();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (y_valid === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got %0d active cycles, expected 0", seen);
    end
  endtask

  task automatic test_unity_latency();
    logic [23:0] exp;
    ref_sample(24'h123456, 0, exp);
    send(24'h123456, 0);
    for (int cyc = 1; cyc <= 35; cyc++) begin
      vectors++;
      if (busy !== (cyc <= 28)) begin
        miscompares++;
        $display("FAIL unity_busy@T+%0d: got %b, expected %b", cyc, busy, (cyc <= 28));
      end
      vectors++;
      if (y_valid !== (cyc == 29)) begin
        miscompares++;
        $display("FAIL unity_yvalid@T+%0d: got %b, expected %b", cyc, y_valid, (cyc == 29));
      end
      if (cyc == 29) begin
        vectors++;
        if (Yout !== 24'h123456 || Yout !== exp) begin
          miscompares++;
          $display("FAIL unity_yout: got %h, expected 123456 (model %h)", Yout, exp);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rounding();
    run_one(24'd3, 1, "round_pos");
    vectors++;
    if (Yout !== 24'd2) begin
      miscompares++;
      $display("FAIL round_pos_value: got %h, expected 000002", Yout);
    end
    run_one(-24'sd3, 1, "round_neg");
    vectors++;
    if (Yout !== 24'hFFFFFF) begin
      miscompares++;
      $display("FAIL round_neg_value: got %h, expected ffffff", Yout);
    end
  endtask

  task automatic test_saturation();
    run_one(24'h7FFFFF, 2, "sat_pos");
    vectors++;
    if (Yout !== 24'h7FFFFF) begin
      miscompares++;
      $display("FAIL sat_pos_value: got %h, expected 7fffff", Yout);
    end
    run_one(24'h800000, 2, "sat_neg");
    vectors++;
    if (Yout !== 24'h800000) begin
      miscompares++;
      $display("FAIL sat_neg_value: got %h, expected 800000", Yout);
    end
  endtask

  task automatic test_overrun();
    logic [23:0] exp, xa;
    int cyc, n_yv, first_yv;
    logic [23:0] y_at;
    xa = 24'($urandom);
    ref_sample(xa, 3, exp);
    send(xa, 3);
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_pre: got %b, expected 0", overrun);
    end
    sample_valid = 1'b1;
    Xin          = ~xa;
    coe_ctrl     = 4'd1;
    @(negedge clk);
    cyc++;
    sample_valid = 1'b0;
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_pulse@T+11: got %b, expected 1", overrun);
    end
    @(negedge clk);
    cyc++;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_width@T+12: got %b, expected 0", overrun);
    end
    n_yv = 0; first_yv = -1; y_at = '0;
    while (cyc < 70) begin
      if (y_valid === 1'b1) begin
        n_yv++;
        if (first_yv < 0) begin
          first_yv = cyc;
          y_at     = Yout;
        end
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (n_yv != 1 || first_yv != 29) begin
      miscompares++;
      $display("FAIL overrun_yvalid: got %0d strobes first at T+%0d, expected 1 at T+29",
               n_yv, first_yv);
    end
    vectors++;
    if (y_at !== exp) begin
      miscompares++;
      $display("FAIL overrun_yout: got %h, expected %h", y_at, exp);
    end
  endtask

  // Random samples and profiles, each accepted in the y_valid cycle of the
  // previous one.
  task automatic test_back_to_back();
    logic [23:0] x, exp;
    int p, lat;
    x = 24'($urandom);
    p = int'($urandom_range(0, 15));
    ref_sample(x, p, exp);
    send(x, p);
    for (int i = 0; i < 24; i++) begin
      wait_yv(lat);
      vectors++;
      if (lat != 29) begin
        miscompares++;
        $display("FAIL b2b_latency[%0d]: got %0d cycles, expected 29", i, lat);
      end
      vectors++;
      if (Yout !== exp) begin
        miscompares++;
        $display("FAIL b2b_yout[%0d]: got %h, expected %h (profile %0d)", i, Yout, exp, p);
      end
      if (i < 23) begin
        case ($urandom_range(0, 3))
          0:       x = ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
          default: x = 24'($urandom);
        endcase
        p = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 15));
        ref_sample(x, p, exp);
        sample_valid = 1'b1;
        Xin          = x;
        coe_ctrl     = 4'(p);
        @(negedge clk);
        sample_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sample();
    int seen;
    logic [23:0] x;
    x = 24'($urandom);
    send(x, 3);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ref_reset();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (y_valid === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midreset_no_output: got %0d active cycles, expected 0", seen);
    end
    vectors++;
    if (Yout !== 24'd0) begin
      miscompares++;
      $display("FAIL midreset_yout: got %h, expected 000000", Yout);
    end
    run_one(24'd1000, 0, "impulse0");
    vectors++;
    if (Yout !== 24'd1000) begin
      miscompares++;
      $display("FAIL impulse0_value: got %h, expected 0003e8", Yout);
    end
    for (int i = 0; i < 2; i++) begin
      run_one(24'd0, 0, "impulse0_tail");
      vectors++;
      if (Yout !== 24'd0) begin
        miscompares++;
        $display("FAIL impulse0_tail_value[%0d]: got %h, expected 000000", i, Yout);
      end
    end
    run_one(24'd1000, 3, "impulse3");
    for (int i = 0; i < 4; i++) run_one(24'd0, 3, "impulse3_tail");
  endtask

  initial begin
    test_reset();
    test_unity_latency();
    test_rounding();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid_sample();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
